// File: rtl/siphash_round_engine.sv
// Handshaked SipRound engine: applies ROUNDS SipRounds to a 4-word state,
// UNROLL rounds per clock, in SipHash (64-bit) or HalfSipHash (32-bit) mode.
module siphash_round_engine #(
  parameter int HALF   = 0,
  parameter int ROUNDS = 2,
  parameter int UNROLL = 1,
  localparam int W     = (HALF != 0) ? 32 : 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] iv0,
  input  logic [W-1:0] iv1,
  input  logic [W-1:0] iv2,
  input  logic [W-1:0] iv3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ov0,
  output logic [W-1:0] ov1,
  output logic [W-1:0] ov2,
  output logic [W-1:0] ov3,
  output logic         busy
);

  localparam int N  = ROUNDS / UNROLL;
  localparam int CW = $clog2(N + 1);

  localparam int ROT_A = (HALF != 0) ? 5  : 13;
  localparam int ROT_B = (HALF != 0) ? 16 : 32;
  localparam int ROT_C = (HALF != 0) ? 8  : 16;
  localparam int ROT_D = (HALF != 0) ? 13 : 17;
  localparam int ROT_E = (HALF != 0) ? 7  : 21;

  if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_params
    $error("siphash_round_engine: ROUNDS must be >= 1 and divisible by UNROLL");
  end

  typedef logic [W-1:0] word_t;
  typedef struct packed {
    word_t v0;
    word_t v1;
    word_t v2;
    word_t v3;
  } state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm, fsm_n;
  state_t        v, v_n, stepped;
  logic [CW-1:0] cnt, cnt_n;

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (W - n));
  endfunction

  // NOTE: inside functions and always_comb, blocking '=' is required so each
  // line sees the value produced by the line before it.
  function automatic state_t sip_round(input state_t s);
    state_t r;
    r    = s;
    r.v0 = r.v0 + r.v1;
    r.v1 = rotl(r.v1, ROT_A) ^ r.v0;
    r.v0 = rotl(r.v0, ROT_B);
    r.v2 = r.v2 + r.v3;
    r.v3 = rotl(r.v3, ROT_C) ^ r.v2;
    r.v2 = r.v2 + r.v1;
    r.v1 = rotl(r.v1, ROT_D) ^ r.v2;
    r.v2 = rotl(r.v2, ROT_B);
    r.v0 = r.v0 + r.v3;
    r.v3 = rotl(r.v3, ROT_E) ^ r.v0;
    return r;
  endfunction

  // UNROLL rounds chained combinationally within one clock.
  always_comb begin
    stepped = v;
    for (int i = 0; i < UNROLL; i++) begin
      stepped = sip_round(stepped);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    fsm_n     = fsm;
    v_n       = v;
    cnt_n     = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          v_n   = '{v0: iv0, v1: iv1, v2: iv2, v3: iv3};
          cnt_n = '0;
          fsm_n = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        v_n   = stepped;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(N - 1)) fsm_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Accepting while the result pops is the only in->out combinational path.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            v_n   = '{v0: iv0, v1: iv1, v2: iv2, v3: iv3};
            cnt_n = '0;
            fsm_n = RUN;
          end else begin
            fsm_n = IDLE;
          end
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  // NOTE: the state words are cleared on reset so ov* read zero out of reset;
  // sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      v   <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_n;
      v   <= v_n;
      cnt <= cnt_n;
    end
  end

  assign ov0 = v.v0;
  assign ov1 = v.v1;
  assign ov2 = v.v2;
  assign ov3 = v.v3;

endmodule

// File: doc/siphash_round_engine.md
Name: siphash_round_engine

Overview:
- Parametrised, handshaked SipRound engine; generalises the single-cycle, registered-input SipRound stage.
- Applies ROUNDS SipRounds to a 4-word state, UNROLL rounds per clock, in either SipHash (64-bit) or HalfSipHash (32-bit) mode.
- Sits between the message-absorb/finalise controller and the state registers of the hash core; serves both compression (c rounds) and finalisation (d rounds) requests.

Parameters:
- HALF, 0, 0 = SipHash (W=64, rotations 13/32/16/21/17/32); 1 = HalfSipHash (W=32, rotations 5/16/8/7/13/16).
- ROUNDS, 2, SipRounds per request; must be >= 1.
- UNROLL, 1, SipRounds per clock; must divide ROUNDS (elaboration error otherwise).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- iv0, iv1, iv2, iv3  in  W each  input state words (W = HALF ? 32 : 64).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- ov0, ov1, ov2, ov3  out  W each  output state words.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async assert, sync deassert by clk): FSM=IDLE, counter=0, state registers v0..v3=0.
  - Outputs during reset: out_valid=0, busy=0, in_ready=1 after reset, ov0..3=0.
- SipRound per unrolled stage, all arithmetic mod 2^W, rotl = rotate left:
  - v0+=v1; v1=rotl(v1,A)^v0; v0=rotl(v0,B).
  - v2+=v3; v3=rotl(v3,C)^v2.
  - v2+=v1; v1=rotl(v1,D)^v2; v2=rotl(v2,B).
  - v0+=v3; v3=rotl(v3,E)^v0.
  - (A,B,C,D,E) = (13,32,16,17,21) for HALF=0 and (5,16,8,13,7) for HALF=1.
- N = ROUNDS/UNROLL. Counter width is clog2(N+1).
- IDLE:
  - in_ready=1.
  - On in_valid: load v*<=iv*, counter<=0, go RUN. No rounds are applied in the load cycle.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle applies UNROLL chained rounds to v*, then counter++.
  - When counter reaches N-1 (in the cycle it applies the last rounds), go DONE.
- DONE:
  - out_valid=1; ov* = v*, held stable until the handshake.
  - If out_ready=0, stay in DONE. v* and ov* are unchanged, and in_ready=0.
  - If out_ready=1 and in_valid=0, go IDLE.
  - If out_ready=1 and in_valid=1: in_ready=1 combinationally, the result pops, the new request loads in the same cycle, and the FSM goes RUN (back-to-back).
  - in_ready in DONE = out_ready. This is the only combinational in->out path.
- Latency:
  - A request accepted at edge t gives out_valid=1 in the cycle after edge t+N.
  - With out_ready held high, throughput is one request per N+1 cycles.
- ov* are driven directly from the state registers; they are meaningful only while out_valid=1.
- in_valid without in_ready (RUN, or DONE with out_ready=0) is ignored. Inputs need not be held; the producer retries.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to reset state; the pending result is discarded.
  - out_valid drops asynchronously.
- No overflow flags; wrap-around of the additions is intended.

Test Plan:
- Zero state, HALF=0, ROUNDS=1, UNROLL=1: iv*=0 -> out_valid 2 cycles after accept; ov*=0 (fixed point).
- HALF=0, ROUNDS=1: iv0=1, iv1..3=0 -> ov0=0x0000000100000000, ov1=0x0000000000020001, ov2=0x0000000100000000, ov3=0x0000000100000000.
- HALF=0, ROUNDS=4, UNROLL=2 vs UNROLL=1, same random iv* -> identical ov*.
  - out_valid appears after 2 and after 4 RUN cycles respectively.
  - Both results match the software model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> ov* stable and in_ready=0; an in_valid pulse in that window is not accepted.
  - Then raise out_ready with in_valid=1 -> pop and load occur in the same cycle; the second result is correct.
- HALF=1, ROUNDS=2, with iv*=0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 -> ov* match the HalfSipHash reference model; upper bits are absent (W=32).
- Assert rst_n=0 for 1 cycle mid-RUN (ROUNDS=4) -> out_valid=0, busy=0, ov*=0 immediately.
  - After release: in_ready=1, and a fresh request completes correctly.
